// File: rtl/data_bus_bridge_pkg.sv
// Shared constants for the MEM-stage data bus bridge: FSM encoding, default
// watchdog limit and the common enable/zero constants.
package data_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_KILL = 3'd4
    } dbus_state_e;

    localparam int          DBUS_TIMEOUT_DEFAULT = 255;
    localparam logic        CHIP_ENABLE          = 1'b1;
    localparam logic        WRITE_ENABLE         = 1'b1;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

    // Watchdog counter is at least 8 bits, wider only when the limit needs it.
    function automatic int dbus_cnt_width(input int timeout);
        return (timeout > 255) ? $clog2(timeout + 1) : 8;
    endfunction

endpackage

// File: rtl/data_bus_bridge_watchdog.sv
// dbus_watchdog: counts cycles of an outstanding bus transaction and flags
// the cycle in which the configured limit is reached.
module dbus_watchdog
    import data_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = DBUS_TIMEOUT_DEFAULT,
    parameter int CW          = dbus_cnt_width(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= r_cnt + 1'b1;
    end

    // The count starts at 0 in the first active cycle, so the limit-th
    // active cycle is the one that sees LIMIT.
    assign expired = en && (r_cnt == LIMIT);

endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: runs one MEM-stage memory access as a req/gnt/ack bus
// transaction, stalling the pipeline until it completes, is flushed or times out.
module data_bus_bridge
    import data_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = DBUS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
);

    dbus_state_e r_state, w_next;

    logic        w_capture;
    logic        w_abort;
    logic        w_zero;
    logic        w_load;
    logic        w_wd_en;
    logic        w_expired;
    logic        w_is_load;
    logic        r_bus_req;
    logic        r_bus_we;
    logic        r_bus_err;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_mem_data;

    assign w_is_load = (r_bus_we != WRITE_ENABLE);

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Ack beats everything; an unflushed timeout beats a bare grant.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        w_zero    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_ce_i == CHIP_ENABLE && !flush_i)
                    w_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus_gnt_i && bus_ack_i) begin
                    w_next    = flush_i ? ST_IDLE : ST_DONE;
                    w_capture = !flush_i;
                end else if (flush_i && !bus_gnt_i) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_zero  = !flush_i;
                    w_next  = flush_i ? ST_IDLE : ST_DONE;
                end else if (bus_gnt_i) begin
                    w_next = flush_i ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_ack_i) begin
                    w_next    = ST_DONE;
                    w_capture = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_zero  = !flush_i;
                    w_next  = flush_i ? ST_IDLE : ST_DONE;
                end else if (flush_i) begin
                    w_next = ST_KILL;
                end
            end
            ST_KILL: begin
                if (bus_ack_i) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        w_wd_en    = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stallreq_o = (mem_ce_i == CHIP_ENABLE) && !flush_i;
                w_load     = (mem_ce_i == CHIP_ENABLE) && !flush_i;
            end
            ST_REQ, ST_WAIT, ST_KILL: begin
                stallreq_o = 1'b1;
                w_wd_en    = 1'b1;
            end
            default: ;
        endcase
        if (!rst)
            stallreq_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_req   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= ZERO_WORD;
            r_bus_sel   <= 4'b0000;
            r_bus_wdata <= ZERO_WORD;
            r_mem_data  <= ZERO_WORD;
        end else begin
            r_bus_req <= (w_next == ST_REQ);
            r_bus_err <= w_abort;
            if (w_load) begin
                r_bus_we    <= mem_we_i;
                r_bus_addr  <= mem_addr_i;
                r_bus_sel   <= mem_sel_i;
                r_bus_wdata <= mem_data_i;
            end
            if (w_capture && w_is_load)
                r_mem_data <= bus_rdata_i;
            else if (w_zero && w_is_load)
                r_mem_data <= ZERO_WORD;
        end
    end

    dbus_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_load),
        .en      (w_wd_en),
        .expired (w_expired)
    );

    assign bus_req_o   = r_bus_req;
    assign bus_err_o   = r_bus_err;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_sel_o   = r_bus_sel;
    assign bus_wdata_o = r_bus_wdata;
    assign mem_data_o  = r_mem_data;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed scenarios plus randomized back-to-back
// transactions checked against a cycle-count model of the bridge.
module tb_data_bus_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i, flush_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic [3:0]  mem_sel_i;
    logic        stallreq_o;
    logic        bus_req_o, bus_we_o, bus_gnt_i, bus_ack_i, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_sel_o;

    int          chk = 0;
    int          err_cnt = 0;
    logic [31:0] model_md;

    always #5 clk = ~clk;

    data_bus_bridge #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .stallreq_o(stallreq_o), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_o(bus_err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_ce_i = 0; mem_we_i = 0; flush_i = 0; bus_gnt_i = 0; bus_ack_i = 0;
        mem_addr_i = $urandom; mem_sel_i = 4'($urandom); mem_data_i = $urandom;
        bus_rdata_i = $urandom;
    endtask

    // Model: ack lands on stall cycle n = 1+g+a; past TO outstanding cycles the
    // watchdog ends it, and DONE is the cycle after the last outstanding one.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input int g, input int a,
                           input logic [31:0] rd, input string tag);
        int n, d;
        bit ab;
        logic [31:0] exp_md;
        n = 1 + g + a;
        ab = (n > TO);
        d = ab ? TO + 1 : n + 1;
        exp_md = we ? model_md : (ab ? 32'h0 : rd);
        for (int k = 0; k <= d; k++) begin
            if (k == 0) begin
                mem_ce_i = 1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wd;
            end else begin
                mem_ce_i = 1; mem_we_i = 1'($urandom); mem_addr_i = $urandom;
                mem_sel_i = 4'($urandom); mem_data_i = $urandom;
            end
            flush_i = 0;
            bus_gnt_i = (k >= 1) && (k < d) && (k == 1 + g);
            bus_ack_i = (k >= 1) && (k < d) && (k == n);
            bus_rdata_i = (k == n) ? rd : $urandom;
            @(negedge clk);
            chk++;
            if (stallreq_o !== (k < d)) begin
                err_cnt++;
                $display("FAIL %s stall k=%0d got %b exp %b", tag, k, stallreq_o, (k < d));
            end
            chk++;
            if (bus_req_o !== (k >= 1 && k <= 1 + g && k < d)) begin
                err_cnt++;
                $display("FAIL %s bus_req k=%0d got %b", tag, k, bus_req_o);
            end
            chk++;
            if (bus_err_o !== (k == d && ab)) begin
                err_cnt++;
                $display("FAIL %s bus_err k=%0d got %b exp %b", tag, k, bus_err_o, (k == d && ab));
            end
            if (k >= 1) begin
                chk++;
                if (bus_we_o !== we || bus_addr_o !== addr || bus_sel_o !== sel || bus_wdata_o !== wd) begin
                    err_cnt++;
                    $display("FAIL %s bus_hold k=%0d got %b %h %h %h exp %b %h %h %h", tag, k,
                             bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, we, addr, sel, wd);
                end
            end
            chk++;
            if (mem_data_o !== ((k == d) ? exp_md : model_md)) begin
                err_cnt++;
                $display("FAIL %s mem_data k=%0d got %h exp %h", tag, k, mem_data_o,
                         (k == d) ? exp_md : model_md);
            end
            step();
        end
        model_md = exp_md;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        mem_ce_i = 1;
        step(); step();
        @(negedge clk);
        chk++;
        if ({stallreq_o, bus_req_o, bus_we_o, bus_err_o} !== 4'b0 || mem_data_o !== 0 ||
            bus_addr_o !== 0 || bus_sel_o !== 0 || bus_wdata_o !== 0) begin
            err_cnt++;
            $display("FAIL reset outputs stall %b req %b md %h addr %h", stallreq_o, bus_req_o,
                     mem_data_o, bus_addr_o);
        end
        step();
        rst = 1;
        mem_ce_i = 0;
        model_md = 0;
        step();
    endtask

    task automatic test_zero_wait_load();
        run_txn(1'b0, 32'h100, 4'b1111, 32'h0, 0, 0, 32'hDEADBEEF, "zero_wait_load");
    endtask

    task automatic test_store_latency();
        run_txn(1'b1, 32'h200, 4'b0011, 32'h1234ABCD, 2, 3, 32'hCAFEF00D, "store_latency");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 40; t++) begin
            int gap;
            run_txn(1'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 4'($urandom),
                    $urandom, $urandom_range(0, 5), $urandom_range(0, 4), $urandom, "b2b");
            gap = (t % 3 == 0) ? $urandom_range(0, 2) : 0;
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                chk++;
                if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL b2b_gap stall %b req %b", stallreq_o, bus_req_o);
                end
                step();
            end
        end
    endtask

    task automatic test_flush_req();
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
        step();
        step();
        flush_i = 1;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b1 || bus_req_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_req in_req stall %b req %b", stallreq_o, bus_req_o);
        end
        step();
        flush_i = 0; mem_ce_i = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || bus_err_o !== 1'b0 || mem_data_o !== model_md) begin
            err_cnt++;
            $display("FAIL flush_req after stall %b req %b err %b md %h exp md %h",
                     stallreq_o, bus_req_o, bus_err_o, mem_data_o, model_md);
        end
        step();
    endtask

    task automatic test_flush_grant();
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h340;
        step();
        bus_gnt_i = 1; flush_i = 1;
        step();
        bus_gnt_i = 0; flush_i = 0; mem_ce_i = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_grant kill stall %b req %b", stallreq_o, bus_req_o);
        end
        bus_ack_i = 1; bus_rdata_i = 32'hBAD0BAD0;
        step();
        bus_ack_i = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0 || mem_data_o !== model_md) begin
            err_cnt++;
            $display("FAIL flush_grant drained stall %b md %h exp %h", stallreq_o, mem_data_o, model_md);
        end
        step();
    endtask

    task automatic test_flush_grant_ack();
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h380;
        step();
        bus_gnt_i = 1; bus_ack_i = 1; flush_i = 1; bus_rdata_i = 32'h0BADF00D;
        step();
        idle_inputs();
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || mem_data_o !== model_md || bus_err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_grant_ack stall %b req %b md %h exp %h", stallreq_o, bus_req_o,
                     mem_data_o, model_md);
        end
        step();
    endtask

    task automatic test_flush_wait();
        logic [31:0] rd;
        rd = $urandom;
        mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h400; mem_sel_i = 4'hF;
        step();
        bus_gnt_i = 1;
        step();
        bus_gnt_i = 0; flush_i = 1;
        step();
        flush_i = 0; mem_ce_i = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_wait kill stall %b req %b", stallreq_o, bus_req_o);
        end
        step();
        bus_ack_i = 1; bus_rdata_i = 32'h55;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_wait held_to_ack stall %b exp 1", stallreq_o);
        end
        step();
        bus_ack_i = 0; mem_ce_i = 1; mem_addr_i = 32'h404;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b1 || mem_data_o !== model_md) begin
            err_cnt++;
            $display("FAIL flush_wait no_done stall %b md %h exp 1 %h", stallreq_o, mem_data_o, model_md);
        end
        step();
        bus_gnt_i = 1; bus_ack_i = 1; bus_rdata_i = rd;
        step();
        idle_inputs();
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0 || mem_data_o !== rd) begin
            err_cnt++;
            $display("FAIL flush_wait next_load stall %b md %h exp %h", stallreq_o, mem_data_o, rd);
        end
        model_md = rd;
        step();
    endtask

    task automatic test_watchdog();
        run_txn(1'b0, 32'h500, 4'hF, 32'h0, 50, 0, 32'h1111_2222, "watchdog_load");
        @(negedge clk);
        chk++;
        if (bus_err_o !== 1'b0 || bus_req_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL watchdog single_pulse err %b req %b", bus_err_o, bus_req_o);
        end
        step();
        run_txn(1'b0, 32'h504, 4'hF, 32'h0, 0, 0, 32'h7777_8888, "watchdog_refill");
        run_txn(1'b1, 32'h508, 4'h1, 32'hAA, 1, 20, 32'h0, "watchdog_store");
    endtask

    task automatic test_reset_mid_wait();
        mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h600; mem_sel_i = 4'hC; mem_data_i = 32'h99;
        step();
        bus_gnt_i = 1;
        step();
        bus_gnt_i = 0; rst = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_mid_wait stall_in_reset got %b exp 0", stallreq_o);
        end
        step();
        rst = 1; mem_ce_i = 0;
        @(negedge clk);
        chk++;
        if ({stallreq_o, bus_req_o, bus_we_o, bus_err_o} !== 4'b0 || mem_data_o !== 0 ||
            bus_addr_o !== 0 || bus_sel_o !== 0 || bus_wdata_o !== 0) begin
            err_cnt++;
            $display("FAIL reset_mid_wait outputs stall %b req %b we %b md %h addr %h",
                     stallreq_o, bus_req_o, bus_we_o, mem_data_o, bus_addr_o);
        end
        model_md = 0;
        bus_ack_i = 1; bus_rdata_i = 32'hFEEDFACE;
        step();
        bus_ack_i = 0;
        @(negedge clk);
        chk++;
        if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || mem_data_o !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_wait late_ack stall %b req %b md %h", stallreq_o, bus_req_o, mem_data_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_latency();
        test_back_to_back();
        test_flush_req();
        test_flush_grant();
        test_flush_grant_ack();
        test_flush_wait();
        test_watchdog();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", chk, err_cnt);
        $finish;
    end

endmodule

// File: doc/data_bus_bridge.md
# data_bus_bridge

Multi-cycle adapter between the combinational MEM stage and an external data bus with request/grant/acknowledge handshaking and variable latency. It captures the MEM stage's memory request (chip enable, write enable, address, byte selects, write data) and runs it as one bus transaction. While the transaction is outstanding it holds the pipeline through `stallreq_o`, then returns read data on `mem_data_o`, which feeds the MEM stage's memory-data input. A watchdog aborts transactions that receive no response.

## Interface
- `TIMEOUT_CYC`, default 255: number of REQ+WAIT cycles before the transaction is aborted; must be ≥2.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `mem_ce_i` in 1: memory access request from the MEM stage.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_addr_i` in 32: word-aligned address.
- `mem_sel_i` in 4: byte enables; bit 3 = bits [31:24] (big-endian lanes).
- `mem_data_i` in 32: store data.
- `mem_data_o` out 32: load data returned to the MEM stage.
- `stallreq_o` out 1: pipeline stall request to ctrl.
- `flush_i` in 1: pipeline flush from ctrl.
- `bus_req_o` out 1: transaction request.
- `bus_we_o` out 1: transaction is a write.
- `bus_addr_o` out 32: transaction address.
- `bus_sel_o` out 4: transaction byte enables.
- `bus_wdata_o` out 32: transaction write data.
- `bus_gnt_i` in 1: request accepted; sampled only while `bus_req_o` = 1.
- `bus_ack_i` in 1: transaction complete; `bus_rdata_i` is valid in the same cycle.
- `bus_rdata_i` in 32: read data.
- `bus_err_o` out 1: one-cycle pulse on a watchdog abort.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - REQ: `bus_req_o` = 1, waiting for grant.
  - WAIT: granted, waiting for acknowledge.
  - DONE: one cycle in which the stall is released.
  - KILL: a flushed transaction is draining.
- **IDLE:**
  - `mem_ce_i` = 1 and `flush_i` = 0 → REQ.
  - On that transition, register `mem_we_i`, `mem_addr_i`, `mem_sel_i` and `mem_data_i` onto the `bus_*` outputs.
- **REQ:**
  - `bus_gnt_i` and `bus_ack_i` both 1 → DONE, capturing the read data.
  - `bus_gnt_i` = 1 only → WAIT.
  - `flush_i` = 1 with no grant → IDLE, and `bus_req_o` drops.
  - Flush and grant in the same cycle → KILL, or → IDLE if the ack also arrives that cycle.
- **WAIT:**
  - `bus_ack_i` = 1 → DONE.
  - `flush_i` = 1 → KILL; a granted transaction is never abandoned.
- **KILL:** `bus_ack_i` = 1 → IDLE; the read data is discarded and `mem_data_o` is unchanged.
- **DONE:** → IDLE unconditionally.
- **Read-data capture:** `mem_data_o` ← `bus_rdata_i` on ack of a load; ← 0 on a watchdog abort of a load. Otherwise it holds its value, including for stores.
- **`stallreq_o`** (combinational):
  - = 1 when in IDLE with `mem_ce_i` & !`flush_i`.
  - = 1 in REQ, WAIT and KILL.
  - = 0 in DONE and otherwise.
- **`bus_req_o`:** registered; it is 1 exactly while in REQ. The `bus_we_o`/`addr`/`sel`/`wdata` outputs stay stable from entering REQ until leaving WAIT or KILL.
- **Watchdog:**
  - An 8-bit-or-wider counter clears on entry to REQ and increments each cycle in REQ, WAIT and KILL.
  - Reaching `TIMEOUT_CYC` → DONE (from KILL → IDLE), `bus_req_o` = 0 and `bus_err_o` = 1 for one cycle.
  - An ack arriving in the same cycle as the timeout takes priority (normal completion).
- **Reset:**
  - State → IDLE.
  - All registered outputs (`mem_data_o`, `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_sel_o`, `bus_wdata_o`, `bus_err_o`) and the counter → 0.
  - `stallreq_o` = 0 while reset is asserted.
  - A reset mid-transaction drops `bus_req_o` on the next edge with no drain.

## Timing
- **Zero-wait bus** (grant and ack in the first REQ cycle):
  - c0 IDLE with `stallreq_o` = 1.
  - c1 REQ.
  - c2 DONE with `stallreq_o` = 0; the MEM stage consumes `mem_data_o`.
  - Result: 2 stall cycles.
- **General case:** stall cycles = 2 + REQ wait cycles + WAIT cycles.
- **Back-to-back accesses:** the next request is sampled in IDLE in c3, so the minimum spacing is 3 cycles per access.
- **Flush timing:** `flush_i` takes effect at the same edge it is sampled.

## Structure
- Constants go in `defines.v`, shared with the rest of the codebase:
  - state encodings (3 bits);
  - `DBusTimeoutDefault`;
  - reuse of the existing `ChipEnable`/`WriteEnable`/`ZeroWord` macros.
- One natural sub-module: `dbus_watchdog`. It holds the counter, with `clr`, `en` and `expired` ports.
- Everything else lives in `data_bus_bridge`.

## Test plan
- **Zero-wait load:**
  - Stimulus: `mem_ce_i` = 1, `we` = 0, `addr` = 0x100, `sel` = 4'b1111; grant and ack on the first REQ cycle with rdata = 0xDEADBEEF.
  - Response: `stallreq_o` = 1 for 2 cycles, then `mem_data_o` = 0xDEADBEEF in DONE.
- **Store with latency:**
  - Stimulus: `we` = 1, `sel` = 4'b0011, data 0x1234ABCD; grant after 2 cycles, ack 3 cycles later.
  - Response: bus outputs stable for the whole transaction; `mem_data_o` unchanged; 7 stall cycles.
- **Flush before grant:**
  - Stimulus: `flush_i` pulses in REQ.
  - Response: `bus_req_o` drops at the next edge, state IDLE, `stallreq_o` = 0.
- **Flush in WAIT:**
  - Stimulus: `flush_i` in WAIT, ack 2 cycles later with rdata = 0x55.
  - Response: stall is held until the ack; `mem_data_o` keeps its old value; no DONE cycle.
- **Watchdog abort:**
  - Stimulus: `TIMEOUT_CYC` = 4 and no grant.
  - Response: `bus_err_o` pulses once, `mem_data_o` = 0, DONE is entered, `bus_req_o` = 0.
- **Reset mid-WAIT:**
  - Stimulus: `rst` = 0 while in WAIT.
  - Response: all outputs are 0 at the next edge, state IDLE; a later ack is ignored.
